// File: rtl/rapid_pkg.sv
// Shared types for the rapid pipeline: memory-stage state/fault enums, the
// control bundle handed between stages, and the load/store width encodings.
package rapid_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'b00,
        MEM_ACCESS = 2'b01,
        MEM_DONE   = 2'b10
    } MEM_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_ILLEGAL    = 2'b10,
        FAULT_TIMEOUT    = 2'b11
    } mem_fault_t;

    // Width encodings carried in fcs_opcode; loads and stores share the low codes.
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef struct packed {
        logic       mem;
        logic       iop;
        logic [2:0] fcs_opcode;
        logic       reg_write;
        logic [4:0] rd_addr;
    } control_s;

    function automatic control_s control_s_default();
        control_s c;
        c.mem        = 1'b0;
        c.iop        = 1'b0;
        c.fcs_opcode = 3'b000;
        c.reg_write  = 1'b0;
        c.rd_addr    = 5'd0;
        return c;
    endfunction

    function automatic mem_fault_t mem_check_fault(input logic       is_store,
                                                   input logic [2:0] funct,
                                                   input logic [1:0] addr_lo);
        mem_fault_t f;
        f = FAULT_NONE;
        if (is_store) begin
            if (funct >= 3'b011)
                f = FAULT_ILLEGAL;
            else if ((funct == SH && addr_lo[0]) || (funct == SW && addr_lo != 2'b00))
                f = FAULT_MISALIGNED;
        end else begin
            if (funct == 3'b011 || funct == 3'b110 || funct == 3'b111)
                f = FAULT_ILLEGAL;
            else if (((funct == LH || funct == LHU) && addr_lo[0]) ||
                     (funct == LW && addr_lo != 2'b00))
                f = FAULT_MISALIGNED;
        end
        return f;
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated data and
// load extraction with sign or zero extension. Also intended for the cache.
module mem_lane_align
    import rapid_pkg::*;
(
    input  logic [2:0]  st_funct,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'd0;
        case (st_funct)
            SB: begin
                st_wstrb = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SH: begin
                st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            SW: begin
                st_wstrb = 4'b1111;
                st_wdata = st_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        lane_half = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
        ld_data   = 32'd0;
        case (ld_funct)
            LB:      ld_data = {{24{lane_byte[7]}}, lane_byte};
            LH:      ld_data = {{16{lane_half[15]}}, lane_half};
            LW:      ld_data = ld_rdata;
            LBU:     ld_data = {24'd0, lane_byte};
            LHU:     ld_data = {16'd0, lane_half};
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: one outstanding req/ack data-bus transaction
// per accepted bundle, with fault detection, ack timeout and a one-cycle WB pulse.
module mem_access_stage
    import rapid_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_ex_done,
    input  control_s        i_control_signal,
    input  logic [XLEN-1:0] i_rd_output,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_mem_ready,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_wstrb,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_valid,
    output logic [XLEN-1:0] o_wb_data,
    output control_s        o_control_signal,
    output mem_fault_t      o_fault
);

    localparam logic [9:0] TIMEOUT_LIMIT = 10'(ACK_TIMEOUT);

    MEM_state_t      state_q, state_d;
    logic [9:0]      cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    control_s        ctrl_q, ctrl_d;
    mem_fault_t      fault_q, fault_d;

    logic [3:0]      st_wstrb;
    logic [31:0]     st_wdata;
    logic [31:0]     ld_data;
    mem_fault_t      accept_fault;

    mem_lane_align u_lane_align (
        .st_funct   (i_control_signal.fcs_opcode),
        .st_addr_lo (i_rd_output[1:0]),
        .st_data    (i_rs2),
        .st_wstrb   (st_wstrb),
        .st_wdata   (st_wdata),
        .ld_funct   (ctrl_q.fcs_opcode),
        .ld_addr_lo (addr_lo_q),
        .ld_rdata   (i_dmem_rdata),
        .ld_data    (ld_data)
    );

    assign accept_fault = mem_check_fault(i_control_signal.iop,
                                          i_control_signal.fcs_opcode,
                                          i_rd_output[1:0]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        addr_lo_d  = addr_lo_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        ctrl_d     = ctrl_q;
        fault_d    = fault_q;
        case (state_q)
            MEM_IDLE: begin
                if (i_ex_done) begin
                    ctrl_d    = i_control_signal;
                    addr_lo_d = i_rd_output[1:0];
                    cnt_d     = 10'd0;
                    fault_d   = FAULT_NONE;
                    wb_data_d = '0;
                    if (!i_control_signal.mem) begin
                        state_d   = MEM_DONE;
                        wb_data_d = i_rd_output;
                    end else if (accept_fault != FAULT_NONE) begin
                        state_d = MEM_DONE;
                        fault_d = accept_fault;
                    end else begin
                        state_d = MEM_ACCESS;
                        req_d   = 1'b1;
                        we_d    = i_control_signal.iop;
                        addr_d  = {i_rd_output[XLEN-1:2], 2'b00};
                        wdata_d = i_control_signal.iop ? st_wdata : '0;
                        wstrb_d = i_control_signal.iop ? st_wstrb : 4'b0000;
                    end
                end
            end
            MEM_ACCESS: begin
                cnt_d = cnt_q + 10'd1;
                // Ack wins over a timeout landing on the same edge.
                if (i_dmem_ack && req_q) begin
                    state_d   = MEM_DONE;
                    wb_data_d = ctrl_q.iop ? '0 : ld_data;
                end else if (cnt_d == TIMEOUT_LIMIT) begin
                    state_d   = MEM_DONE;
                    fault_d   = FAULT_TIMEOUT;
                    wb_data_d = '0;
                end
                if (state_d == MEM_DONE) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    wstrb_d = 4'b0000;
                end
            end
            MEM_DONE: begin
                wb_valid_d = 1'b1;
                state_d    = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= 10'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'b0000;
            addr_lo_q  <= 2'b00;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            ctrl_q     <= control_s_default();
            fault_q    <= FAULT_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            addr_lo_q  <= addr_lo_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            ctrl_q     <= ctrl_d;
            fault_q    <= fault_d;
        end
    end

    assign o_mem_ready      = (state_q == MEM_IDLE);
    assign o_dmem_req       = req_q;
    assign o_dmem_we        = we_q;
    assign o_dmem_addr      = addr_q;
    assign o_dmem_wdata     = wdata_q;
    assign o_dmem_wstrb     = wstrb_q;
    assign o_wb_valid       = wb_valid_q;
    assign o_wb_data        = wb_data_q;
    assign o_control_signal = ctrl_q;
    assign o_fault          = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage: table of loads/stores/faults,
// plus hand sequences for reset state, reset mid-access and stray acks.
module tb_mem_access_stage;
    import rapid_pkg::*;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_done;
    control_s    ctrl_in;
    logic [31:0] rd_output;
    logic [31:0] rs2;
    logic        mem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    control_s    ctrl_out;
    mem_fault_t  fault;

    int num_checks = 0;
    int num_fail   = 0;

    typedef struct {
        string       name;
        logic        mem;
        logic        iop;
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          ack_wait;
        logic        bus;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
        mem_fault_t  exp_fault;
    } vec_t;

    vec_t vecs[15];

    mem_access_stage #(.XLEN(32), .ACK_TIMEOUT(TB_TIMEOUT)) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_ex_done        (ex_done),
        .i_control_signal (ctrl_in),
        .i_rd_output      (rd_output),
        .i_rs2            (rs2),
        .o_mem_ready      (mem_ready),
        .o_dmem_req       (dmem_req),
        .o_dmem_we        (dmem_we),
        .o_dmem_addr      (dmem_addr),
        .o_dmem_wdata     (dmem_wdata),
        .o_dmem_wstrb     (dmem_wstrb),
        .i_dmem_ack       (dmem_ack),
        .i_dmem_rdata     (dmem_rdata),
        .o_wb_valid       (wb_valid),
        .o_wb_data        (wb_data),
        .o_control_signal (ctrl_out),
        .o_fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name, input logic mem, input logic iop,
                                input logic [2:0] funct, input logic [31:0] addr,
                                input logic [31:0] rs2_v, input logic [31:0] rdata,
                                input int ack_wait, input logic bus,
                                input logic [31:0] eaddr, input logic ewe,
                                input logic [3:0] estrb, input logic [31:0] ewdata,
                                input logic [31:0] ewb, input mem_fault_t efault);
        vec_t v;
        v.name = name; v.mem = mem; v.iop = iop; v.funct = funct;
        v.addr = addr; v.rs2 = rs2_v; v.rdata = rdata; v.ack_wait = ack_wait;
        v.bus = bus; v.exp_addr = eaddr; v.exp_we = ewe; v.exp_wstrb = estrb;
        v.exp_wdata = ewdata; v.exp_wb = ewb; v.exp_fault = efault;
        return v;
    endfunction

    // Called at a negedge with the stage idle; returns at a negedge, idle again.
    task automatic run_vector(input vec_t v);
        control_s    c;
        control_s    got_ctrl;
        int          wb_n;
        int          req_cycles;
        int          exp_n;
        int          exp_req;
        logic [31:0] got_wb;
        mem_fault_t  got_fault;
        c            = control_s_default();
        c.mem        = v.mem;
        c.iop        = v.iop;
        c.fcs_opcode = v.funct;
        c.reg_write  = !v.iop;
        c.rd_addr    = 5'd9;
        exp_req = !v.bus ? 0 : (v.ack_wait >= 0 ? v.ack_wait + 1 : TB_TIMEOUT);
        exp_n   = !v.bus ? 1 : (v.ack_wait >= 0 ? v.ack_wait + 2 : TB_TIMEOUT + 1);
        check($sformatf("%s.ready", v.name), {31'd0, mem_ready}, 32'd1);
        ex_done   = 1'b1;
        ctrl_in   = c;
        rd_output = v.addr;
        rs2       = v.rs2;
        @(posedge clk);
        wb_n       = -1;
        req_cycles = 0;
        got_wb     = '0;
        got_fault  = FAULT_NONE;
        got_ctrl   = control_s_default();
        for (int n = 0; n < 40 && wb_n < 0; n++) begin
            @(negedge clk);
            ex_done    = 1'b0;
            dmem_ack   = 1'b0;
            dmem_rdata = '0;
            if (dmem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    check($sformatf("%s.addr", v.name), dmem_addr, v.exp_addr);
                    check($sformatf("%s.we", v.name), {31'd0, dmem_we}, {31'd0, v.exp_we});
                    check($sformatf("%s.wstrb", v.name), {28'd0, dmem_wstrb}, {28'd0, v.exp_wstrb});
                    check($sformatf("%s.wdata", v.name), dmem_wdata, v.exp_wdata);
                end
                if (v.ack_wait >= 0 && req_cycles == v.ack_wait + 1) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = v.rdata;
                end
            end
            if (wb_valid) begin
                wb_n      = n;
                got_wb    = wb_data;
                got_fault = fault;
                got_ctrl  = ctrl_out;
            end
        end
        check($sformatf("%s.latency", v.name), wb_n, exp_n);
        check($sformatf("%s.req_cycles", v.name), req_cycles, exp_req);
        check($sformatf("%s.wb_data", v.name), got_wb, v.exp_wb);
        check($sformatf("%s.fault", v.name), {30'd0, got_fault}, {30'd0, v.exp_fault});
        check($sformatf("%s.ctrl", v.name), {22'd0, got_ctrl}, {22'd0, c});
        @(negedge clk);
        dmem_ack = 1'b0;
        check($sformatf("%s.wb_pulse", v.name), {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wb_seen;
        reset_n    = 1'b0;
        ex_done    = 1'b0;
        ctrl_in    = control_s_default();
        rd_output  = '0;
        rs2        = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;

        vecs[0]  = mk("lw_wait3", 1, 0, LW,  32'h100, 32'h0, 32'hDEADBEEF, 3, 1, 32'h100, 0, 4'h0, 32'h0, 32'hDEADBEEF, FAULT_NONE);
        vecs[1]  = mk("lb_neg",   1, 0, LB,  32'h103, 32'h0, 32'h80123456, 0, 1, 32'h100, 0, 4'h0, 32'h0, 32'hFFFFFF80, FAULT_NONE);
        vecs[2]  = mk("lbu",      1, 0, LBU, 32'h103, 32'h0, 32'h80123456, 0, 1, 32'h100, 0, 4'h0, 32'h0, 32'h00000080, FAULT_NONE);
        vecs[3]  = mk("sh_hi",    1, 1, SH,  32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1, 1, 32'h200, 1, 4'hC, 32'hABCDABCD, 32'h0, FAULT_NONE);
        vecs[4]  = mk("lw_mis",   1, 0, LW,  32'h101, 32'h0, 32'h0, -1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, FAULT_MISALIGNED);
        vecs[5]  = mk("ld_ill",   1, 0, 3'b111, 32'h100, 32'h0, 32'h0, -1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, FAULT_ILLEGAL);
        vecs[6]  = mk("add_pass", 0, 0, 3'b000, 32'h55, 32'h0, 32'h0, -1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h55, FAULT_NONE);
        vecs[7]  = mk("sb_lane1", 1, 1, SB,  32'h101, 32'h000000A5, 32'h0, 0, 1, 32'h100, 1, 4'h2, 32'hA5A5A5A5, 32'h0, FAULT_NONE);
        vecs[8]  = mk("lh_hi",    1, 0, LH,  32'h102, 32'h0, 32'h80017FFF, 2, 1, 32'h100, 0, 4'h0, 32'h0, 32'hFFFF8001, FAULT_NONE);
        vecs[9]  = mk("lhu_lo",   1, 0, LHU, 32'h100, 32'h0, 32'h12348765, 0, 1, 32'h100, 0, 4'h0, 32'h0, 32'h00008765, FAULT_NONE);
        vecs[10] = mk("sw",       1, 1, SW,  32'h300, 32'hCAFEF00D, 32'h0, 0, 1, 32'h300, 1, 4'hF, 32'hCAFEF00D, 32'h0, FAULT_NONE);
        vecs[11] = mk("sh_mis",   1, 1, SH,  32'h203, 32'h1111, 32'h0, -1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, FAULT_MISALIGNED);
        vecs[12] = mk("st_ill",   1, 1, 3'b011, 32'h200, 32'h0, 32'h0, -1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, FAULT_ILLEGAL);
        vecs[13] = mk("lw_tmo",   1, 0, LW,  32'h104, 32'h0, 32'h0, -1, 1, 32'h104, 0, 4'h0, 32'h0, 32'h0, FAULT_TIMEOUT);
        vecs[14] = mk("lb_pos",   1, 0, LB,  32'h101, 32'h0, 32'h00007F00, 0, 1, 32'h100, 0, 4'h0, 32'h0, 32'h0000007F, FAULT_NONE);

        repeat (3) @(negedge clk);
        check("rst.req",      {31'd0, dmem_req}, 32'd0);
        check("rst.we",       {31'd0, dmem_we}, 32'd0);
        check("rst.addr",     dmem_addr, 32'd0);
        check("rst.wdata",    dmem_wdata, 32'd0);
        check("rst.wstrb",    {28'd0, dmem_wstrb}, 32'd0);
        check("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst.wb_data",  wb_data, 32'd0);
        check("rst.fault",    {30'd0, fault}, 32'd0);
        check("rst.ctrl",     {22'd0, ctrl_out}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst.ready", {31'd0, mem_ready}, 32'd1);

        // A stray ack while idle must not produce anything.
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_ack = 1'b0;
        wb_seen  = 0;
        repeat (3) begin
            @(negedge clk);
            if (wb_valid || dmem_req) wb_seen++;
        end
        check("stray_ack.idle", wb_seen, 0);

        for (int i = 0; i < 15; i++) run_vector(vecs[i]);

        // Reset asserted while a load is outstanding.
        ex_done      = 1'b1;
        ctrl_in      = control_s_default();
        ctrl_in.mem  = 1'b1;
        ctrl_in.fcs_opcode = LW;
        rd_output    = 32'h400;
        @(posedge clk);
        @(negedge clk);
        ex_done = 1'b0;
        check("midrst.req_before", {31'd0, dmem_req}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst.req_drop", {31'd0, dmem_req}, 32'd0);
        check("midrst.wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        reset_n    = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        dmem_ack = 1'b0;
        wb_seen  = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_valid || dmem_req) wb_seen++;
        end
        check("midrst.no_wb", wb_seen, 0);
        check("midrst.ready", {31'd0, mem_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
